// File: rtl/booth_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// booth_pkg : shared default sizing for the operand staging path
// Rev 1.0
// ------------------------------------------------------------------
package booth_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/operand_buf_mem.sv
`default_nettype none
// ------------------------------------------------------------------
// operand_buf_mem : operand storage, one write port, registered read port
// Rev 1.0
// ------------------------------------------------------------------
module operand_buf_mem #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Read sees pre-write contents when both ports hit the same entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= r_mem[rd_addr];
      end
   end

   assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/operand_stage_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// operand_stage_buffer : FIFO staging of operands with registered pop output
// Rev 1.0
// ------------------------------------------------------------------
module operand_stage_buffer
   import booth_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in,
   input  logic                       ld,
   input  logic                       en,
   input  logic                       clr,
   output logic [WIDTH-1:0]           out,
   output logic                       out_valid,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_out_valid;
   logic          r_overflow;
   logic          w_pop;
   logic          w_push;

   assign full   = (r_count == C_DEPTH);
   assign empty  = (r_count == '0);
   assign w_pop  = en && !empty;
   assign w_push = ld && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (clr) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_out_valid <= w_pop;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
         if (ld && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // out is the memory's read register: it reloads only on an accepted pop.
   operand_buf_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (reset && !clr && w_push),
      .wr_addr (r_wr_ptr),
      .wr_data (in),
      .rd_en   (reset && !clr && w_pop),
      .rd_addr (r_rd_ptr),
      .rd_data (out)
   );

   assign out_valid = r_out_valid;
   assign count     = r_count;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_operand_stage_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_operand_stage_buffer : queue-model scoreboard plus directed literal checks
// Rev 1.0
// ------------------------------------------------------------------
module tb_operand_stage_buffer;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in;
   logic             ld;
   logic             en;
   logic             clr;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             full;
   logic             empty;
   logic [2:0]       count;
   logic             overflow;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_out   = '0;
   logic             m_valid = 1'b0;
   logic             m_ovf   = 1'b0;

   operand_stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .ld        (ld),
      .en        (en),
      .clr       (clr),
      .out       (out),
      .out_valid (out_valid),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a plain queue, updated from the inputs seen at each edge.
   always @(posedge clk) begin
      bit pop;
      bit push;
      if (!reset) begin
         q.delete();
         m_out   = '0;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
      end else if (clr) begin
         q.delete();
         m_valid = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         pop  = en && (q.size() > 0);
         push = ld && ((q.size() < DEPTH) || pop);
         m_valid = pop;
         if (pop) m_out = q.pop_front();
         if (push) q.push_back(in);
         else if (ld) m_ovf = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_out",       32'(out),       32'(m_out));
         chk("m_out_valid", 32'(out_valid), 32'(m_valid));
         chk("m_count",     32'(count),     32'(q.size()));
         chk("m_full",      32'(full),      32'(q.size() == DEPTH));
         chk("m_empty",     32'(empty),     32'(q.size() == 0));
         chk("m_overflow",  32'(overflow),  32'(m_ovf));
      end
   end

   // Drive one cycle's inputs at a falling edge; returns at the next falling edge.
   task automatic cyc(input logic l, input logic e, input logic c, input logic [WIDTH-1:0] d);
      ld  = l;
      en  = e;
      clr = c;
      in  = d;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      cyc(0, 0, 0, '0);
      chk_en = 1'b1;
      cyc(1, 1, 1, 16'hFFFF);
      chk("rst_out",   32'(out), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_full",  32'(full), 32'h0);
      chk("rst_ovf",   32'(overflow), 32'h0);
      reset = 1'b1;

      // Basic FIFO order, one-cycle out_valid pulse
      cyc(1, 0, 0, 16'h1111);
      cyc(1, 0, 0, 16'h2222);
      cyc(1, 0, 0, 16'h3333);
      chk("b_count3", 32'(count), 32'h3);
      cyc(0, 1, 0, '0);
      chk("b_pop1", 32'(out), 32'h1111);
      chk("b_v1",   32'(out_valid), 32'h1);
      cyc(0, 0, 0, '0);
      chk("b_vdrop", 32'(out_valid), 32'h0);
      chk("b_hold",  32'(out), 32'h1111);
      cyc(0, 1, 0, '0);
      chk("b_pop2", 32'(out), 32'h2222);
      cyc(0, 1, 0, '0);
      chk("b_pop3", 32'(out), 32'h3333);
      chk("b_empty", 32'(empty), 32'h1);
      cyc(0, 1, 0, '0);
      chk("b_pop_empty_v", 32'(out_valid), 32'h0);
      chk("b_pop_empty_o", 32'(out), 32'h3333);

      // Overflow on a fifth push with no pop
      for (int i = 1; i <= 5; i++) begin
         cyc(1, 0, 0, 16'hA000 + 16'(i));
         if (i == 4) chk("o_full4", 32'(full), 32'h1);
      end
      chk("o_ovf",   32'(overflow), 32'h1);
      chk("o_count", 32'(count), 32'h4);
      for (int i = 1; i <= 4; i++) begin
         cyc(0, 1, 0, '0);
         chk("o_pop", 32'(out), 32'hA000 + 32'(i));
      end
      chk("o_sticky", 32'(overflow), 32'h1);
      cyc(0, 0, 1, '0);
      chk("o_clr_ovf", 32'(overflow), 32'h0);
      chk("o_clr_out", 32'(out), 32'hA004);

      // Full buffer with simultaneous push and pop
      for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 16'hC000 + 16'(i));
      cyc(1, 1, 0, 16'hBEEF);
      chk("f_count", 32'(count), 32'h4);
      chk("f_out",   32'(out), 32'hC001);
      chk("f_ovf",   32'(overflow), 32'h0);
      cyc(0, 1, 0, '0);
      cyc(0, 1, 0, '0);
      cyc(0, 1, 0, '0);
      chk("f_c004", 32'(out), 32'hC004);
      cyc(0, 1, 0, '0);
      chk("f_beef", 32'(out), 32'hBEEF);

      // No bypass into an empty buffer
      cyc(1, 1, 0, 16'h0042);
      chk("e_v",     32'(out_valid), 32'h0);
      chk("e_count", 32'(count), 32'h1);
      cyc(0, 1, 0, '0);
      chk("e_out", 32'(out), 32'h0042);

      // Interleaved traffic across the pointer wrap, then clr with two staged
      cyc(1, 0, 0, 16'hD001);
      cyc(1, 0, 0, 16'hD002);
      for (int i = 3; i <= 6; i++) begin
         cyc(1, 1, 0, 16'hD000 + 16'(i));
         chk("w_pop", 32'(out), 32'hD000 + 32'(i) - 32'h2);
      end
      cyc(0, 1, 0, '0);
      cyc(0, 1, 0, '0);
      chk("w_last", 32'(out), 32'hD006);
      cyc(1, 0, 0, 16'hE001);
      cyc(1, 0, 0, 16'hE002);
      cyc(1, 1, 1, 16'hE003);
      chk("c_count", 32'(count), 32'h0);
      chk("c_ovf",   32'(overflow), 32'h0);
      chk("c_out",   32'(out), 32'hD006);
      chk("c_v",     32'(out_valid), 32'h0);

      // Reset mid-operation
      cyc(1, 0, 0, 16'h1234);
      cyc(0, 1, 0, '0);
      chk("r_pre_out", 32'(out), 32'h1234);
      cyc(1, 0, 0, 16'h0001);
      cyc(1, 0, 0, 16'h0002);
      cyc(1, 0, 0, 16'h0003);
      reset = 1'b0;
      cyc(0, 0, 0, '0);
      chk("r_out",   32'(out), 32'h0);
      chk("r_count", 32'(count), 32'h0);
      chk("r_empty", 32'(empty), 32'h1);
      reset = 1'b1;
      cyc(1, 0, 0, 16'h5555);
      cyc(0, 1, 0, '0);
      chk("r_post", 32'(out), 32'h5555);
      cyc(0, 0, 0, '0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/operand_stage_buffer.md
OPERAND_STAGE_BUFFER -- requirements
Module: operand_stage_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand bit width (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of staged operands (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port in  input  WIDTH  operand to stage.
REQ-006 SHALL have port ld  input  1  push in into buffer.
REQ-007 SHALL have port en  input  1  pop oldest staged operand to out.
REQ-008 SHALL have port clr  input  1  synchronous flush of staged contents.
REQ-009 SHALL have port out  output  WIDTH  last popped operand, registered.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse, out updated this cycle.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of staged operands.
REQ-014 SHALL have port overflow  output  1  sticky: a push was dropped.

Function
REQ-015 SHALL store operands in FIFO order; out presents oldest entry one cycle after accepted pop (latency 1).
REQ-016 Push accepted when ld=1 and (not full, or en=1 with pop accepted same cycle).
REQ-017 Pop accepted when en=1 and not empty; no bypass: push into empty buffer not poppable same cycle.
REQ-018 Accepted pop: out <= head entry, out_valid <= 1 next cycle; otherwise out_valid <= 0 and out holds.
REQ-019 en with empty buffer: out holds, out_valid 0, no pointer change, no error.
REQ-020 ld with full and no accepted pop: operand dropped, contents unchanged, overflow <= 1.
REQ-021 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-022 Read/write pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 without extra logic.
REQ-023 count SHALL increment on push-only, decrement on pop-only, never exceed DEPTH or go below 0.
REQ-024 full, empty SHALL be registered-consistent with count in the same cycle (derived from count).
REQ-025 clr=1 (priority over ld/en): pointers, count, overflow <= 0; out retained; out_valid <= 0.
REQ-026 overflow SHALL clear only on reset or clr.

Reset
REQ-027 reset=0 at rising edge: out=0, out_valid=0, count=0, empty=1, full=0, overflow=0, pointers=0.
REQ-028 Reset SHALL take priority over clr, ld, en; storage array contents need not be cleared.
REQ-029 Reset mid-operation SHALL discard all staged operands; first pop after release returns first post-reset push.

Structure
REQ-030 Default WIDTH/DEPTH constants SHALL live in shared package booth_pkg.
REQ-031 Storage array SHALL be sub-module operand_buf_mem (write port, registered read port); pointer/count control in top.

Verification (WIDTH=16, DEPTH=4)
REQ-032 Push 0x1111,0x2222,0x3333; three pops -> out 0x1111,0x2222,0x3333, each with out_valid pulse 1 cycle after en, then empty=1.
REQ-033 Push 5 values 0xA001..0xA005 no pops -> full=1 after 4th, 5th dropped, overflow=1; 4 pops return 0xA001..0xA004.
REQ-034 Full buffer, ld=1 en=1 with in=0xBEEF -> count stays 4, out=oldest, 0xBEEF popped 4th afterwards; overflow stays 0.
REQ-035 Empty buffer, ld=1 en=1 in=0x0042 -> no pop, out_valid=0, count=1; next en -> out=0x0042.
REQ-036 Push 6 and pop 6 interleaved across pointer wrap -> order preserved; clr with 2 staged -> count=0, overflow=0, out retained.
REQ-037 reset=0 with 3 staged, out=0x1234 -> out=0, count=0, empty=1; post-release push 0x5555, pop -> out 0x5555.
